multi_spinner: RTL and testbench
================================

Name: multi_spinner

Overview:
- Parametrised N-channel digital-to-rotary input emulator. Converts per-player left/right buttons into wrapping wheel/spinner angles for arcade cores.
- Replaces per-player fixed-rate spinner instances. Adds acceleration ramp, fast modifier, synchronous preset and per-channel inversion.
- Sits between the arcade input decoder and the core's wheel inputs. Updates on a frame-rate tick, typically core vsync.

Parameters:
- NUM_CH, 4: number of independent channels.
- ANGLE_W, 6: angle width in bits; angle wraps modulo 2^ANGLE_W.
- MAX_STEP, 3: maximum acceleration step per tick (>=1).
- ACC_HOLD, 8: ticks held in one direction before step increments (>=1).
- RESET_ANGLE, 0: angle value loaded on reset and on preset.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- tick  in  1  update strobe (level, e.g. vsync); rising edge detected internally.
- preset  in  1  synchronous strobe; loads all angles to RESET_ANGLE.
- btn_left  in  NUM_CH  per-channel counter-clockwise button, active high.
- btn_right  in  NUM_CH  per-channel clockwise button, active high.
- btn_fast  in  NUM_CH  per-channel step doubler, active high.
- invert  in  NUM_CH  per-channel swap of left/right meaning.
- angle  out  NUM_CH*ANGLE_W  packed angles, channel 0 in LSBs.
- moving  out  NUM_CH  channel changed angle on last tick.

Behaviour:
- Clock and reset: one clock, clk_sys. reset_n is asynchronous, active-low.
- Reset values:
  - angle = RESET_ANGLE, moving = 0.
  - Internal step = 1, hold = 0, dir = IDLE.
  - tick_d = 1, so a tick already high at reset release does not fire.
- Tick detection:
  - rise = tick & ~tick_d.
  - The update happens on the clk_sys edge ending the cycle where rise = 1.
  - Outputs are registered and visible the next cycle (1-cycle latency).
  - Tick held high for many cycles produces exactly one update.
- Direction, after invert swap:
  - right & ~left = CW.
  - left & ~right = CCW.
  - Neither or both = IDLE.
- Per channel, on rise:
  - IDLE: angle unchanged; step <= 1; hold <= 0; moving <= 0.
  - Same direction as previous dir:
    - angle += eff (CW) or -= eff (CCW), modulo 2^ANGLE_W.
    - eff = btn_fast ? 2*step : step, using the step value before this tick's update.
    - If hold == ACC_HOLD-1: hold <= 0, and step <= min(step+1, MAX_STEP). Otherwise hold <= hold+1.
  - New or reversed direction: angle moves by eff computed with step = 1; step <= 1; hold <= 1 (or 0 if ACC_HOLD == 1, in which case step <= min(2, MAX_STEP)).
  - moving <= 1 whenever angle changed. dir register <= current direction.
- Between rises: all state holds; buttons are ignored.
- preset:
  - Has priority over a coincident rise.
  - Angles <= RESET_ANGLE, step <= 1, hold <= 0, moving <= 0, dir <= IDLE.
- Arithmetic and widths:
  - step register width = clog2(MAX_STEP+1).
  - eff width = step width + 1.
  - Sum computed at ANGLE_W+1 bits and truncated; no saturation.
- Reset mid-operation: asynchronous clear of all state regardless of tick phase.

Optional Feature:
- Macro: MULTI_SPINNER_RECENTER_EN.
- Defined: on rise, an IDLE channel moves 1 toward CENTER = 2^(ANGLE_W-1) without wrapping:
  - angle > CENTER: decrement.
  - angle < CENTER: increment.
  - angle == CENTER: hold.
  - moving = 1 if the angle changed.
  - Models a self-centering steering wheel.
- Undefined: IDLE channel holds its angle.
- All other behaviour is identical in both builds.

Decomposition:
- Package multi_spinner_pkg holds:
  - dir_t enum {DIR_IDLE, DIR_CW, DIR_CCW}.
  - clog2-based width function.
  - CENTER derivation.
- One sub-module, spinner_ch: per-channel direction decode, step/hold counters and angle register. Takes shared rise and preset.
- Top level holds the tick edge detector and a generate loop of NUM_CH spinner_ch instances.

Test Plan (NUM_CH=4, ANGLE_W=6, MAX_STEP=3, ACC_HOLD=4, RESET_ANGLE=0, recenter off unless stated):
- Ramp: ch0 right held for 10 ticks -> angle after each tick 1,2,3,4,6,8,10,12,15,18; moving0=1; other channels stay 0.
- Wrap and fast:
  - From 0, ch1 left for 1 tick -> 63.
  - From 0, ch1 right+fast for 1 tick -> 2.
  - ch1 at 62, right+fast -> 0.
- Idle, both and reversal:
  - ch2 ramped to step 2, then both pressed for 1 tick -> angle unchanged, moving2=0; next right tick adds 1.
  - ch2 right reversed to left -> first left tick subtracts 1.
- Tick and preset:
  - tick held high for 50 cycles -> single update.
  - preset coincident with rise -> all angles 0, no step applied.
  - invert3=1 with right -> angle3 decrements.
- Reset: reset_n pulsed low mid-ramp, between clock edges -> angle and moving clear immediately; tick high at release causes no update.
- Recenter build, ch0 at 35 with no buttons -> 34, 33, 32, 32 over 4 ticks.

Source files
------------

// File: rtl/multi_spinner_pkg.sv
// Shared types and width helpers for the multi-channel spinner emulator.
// Optional build macro: MULTI_SPINNER_RECENTER_EN (self-centering idle channels).
package multi_spinner_pkg;

    typedef enum logic [1:0] {
        DIR_IDLE,
        DIR_CW,
        DIR_CCW
    } dir_t;

    // Bits needed to hold values 0..v (clog2(v+1), at least 1).
    function automatic int width_of(input int v);
        int w;
        w = 1;
        while ((1 << w) <= v) w++;
        return w;
    endfunction

    function automatic int center_of(input int aw);
        return 1 << (aw - 1);
    endfunction

endpackage

// File: rtl/multi_spinner_ch.sv
// One spinner channel: direction decode, acceleration counters, angle register.
// With MULTI_SPINNER_RECENTER_EN an idle channel drifts one step toward centre.
module spinner_ch
    import multi_spinner_pkg::*;
#(
    parameter int ANGLE_W     = 6,
    parameter int MAX_STEP    = 3,
    parameter int ACC_HOLD    = 8,
    parameter int RESET_ANGLE = 0
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               rise,
    input  logic               preset,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_fast,
    input  logic               invert,
    output logic [ANGLE_W-1:0] angle,
    output logic               moving
);

    localparam int SW = width_of(MAX_STEP);
    localparam int HW = width_of(ACC_HOLD);
    localparam int NEW_STEP = (MAX_STEP < 2) ? MAX_STEP : 2;

    localparam logic [ANGLE_W-1:0] RST_A = ANGLE_W'(RESET_ANGLE);
    localparam logic [ANGLE_W-1:0] CTR   = ANGLE_W'(center_of(ANGLE_W));
    localparam logic [ANGLE_W-1:0] A_ONE = ANGLE_W'(1);
    localparam logic [SW-1:0]      S_ONE = SW'(1);
    localparam logic [SW-1:0]      S_MAX = SW'(MAX_STEP);
    localparam logic [SW-1:0]      S_NEW = (ACC_HOLD == 1) ? SW'(NEW_STEP) : S_ONE;
    localparam logic [HW-1:0]      H_ONE = HW'(1);
    localparam logic [HW-1:0]      H_NEW = (ACC_HOLD == 1) ? '0 : H_ONE;
    localparam logic [HW-1:0]      H_END = HW'(ACC_HOLD - 1);

    logic [ANGLE_W-1:0] ang_q, ang_d;
    logic [SW-1:0]      step_q, step_d, base;
    logic [HW-1:0]      hold_q, hold_d;
    logic [SW:0]        eff;
    logic [ANGLE_W:0]   ext, sum;
    logic               lft, rgt, same, mov_q;
    dir_t               dir_q, cur;

    assign lft = invert ? btn_right : btn_left;
    assign rgt = invert ? btn_left : btn_right;

    always_comb begin
        cur = DIR_IDLE;
        if (rgt && !lft) cur = DIR_CW;
        else if (lft && !rgt) cur = DIR_CCW;
    end

    // A new or reversed direction always restarts from step 1.
    assign same = (cur == dir_q);
    assign base = same ? step_q : S_ONE;
    assign eff  = btn_fast ? {base, 1'b0} : {1'b0, base};
    assign ext  = (ANGLE_W + 1)'(eff);
    assign sum  = (cur == DIR_CW) ? ({1'b0, ang_q} + ext)
                                  : ({1'b0, ang_q} - ext);

    always_comb begin
        ang_d  = ang_q;
        step_d = step_q;
        hold_d = hold_q;
        if (cur == DIR_IDLE) begin
            step_d = S_ONE;
            hold_d = '0;
`ifdef MULTI_SPINNER_RECENTER_EN
            if (ang_q > CTR) ang_d = ang_q - A_ONE;
            else if (ang_q < CTR) ang_d = ang_q + A_ONE;
`endif
        end else begin
            ang_d = sum[ANGLE_W-1:0];
            if (!same) begin
                step_d = S_NEW;
                hold_d = H_NEW;
            end else if (hold_q == H_END) begin
                hold_d = '0;
                step_d = (step_q < S_MAX) ? step_q + S_ONE : step_q;
            end else begin
                hold_d = hold_q + H_ONE;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ang_q  <= RST_A;
            step_q <= S_ONE;
            hold_q <= '0;
            dir_q  <= DIR_IDLE;
            mov_q  <= 1'b0;
        end else if (preset) begin
            ang_q  <= RST_A;
            step_q <= S_ONE;
            hold_q <= '0;
            dir_q  <= DIR_IDLE;
            mov_q  <= 1'b0;
        end else if (rise) begin
            ang_q  <= ang_d;
            step_q <= step_d;
            hold_q <= hold_d;
            dir_q  <= cur;
            mov_q  <= (ang_d != ang_q);
        end
    end

    assign angle  = ang_q;
    assign moving = mov_q;

endmodule

// File: rtl/multi_spinner.sv
// N-channel button-to-rotary emulator; tick edge detect plus per-channel spinners.
// Optional build macro: MULTI_SPINNER_RECENTER_EN.
module multi_spinner
    import multi_spinner_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int ANGLE_W     = 6,
    parameter int MAX_STEP    = 3,
    parameter int ACC_HOLD    = 8,
    parameter int RESET_ANGLE = 0
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic                      tick,
    input  logic                      preset,
    input  logic [NUM_CH-1:0]         btn_left,
    input  logic [NUM_CH-1:0]         btn_right,
    input  logic [NUM_CH-1:0]         btn_fast,
    input  logic [NUM_CH-1:0]         invert,
    output logic [NUM_CH*ANGLE_W-1:0] angle,
    output logic [NUM_CH-1:0]         moving
);

    logic tick_d;
    logic rise;

    // Reset to 1 so a tick already high at reset release is not an edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) tick_d <= 1'b1;
        else          tick_d <= tick;
    end

    assign rise = tick & ~tick_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        spinner_ch #(
            .ANGLE_W    (ANGLE_W),
            .MAX_STEP   (MAX_STEP),
            .ACC_HOLD   (ACC_HOLD),
            .RESET_ANGLE(RESET_ANGLE)
        ) u_ch (
            .clk_sys  (clk_sys),
            .reset_n  (reset_n),
            .rise     (rise),
            .preset   (preset),
            .btn_left (btn_left[i]),
            .btn_right(btn_right[i]),
            .btn_fast (btn_fast[i]),
            .invert   (invert[i]),
            .angle    (angle[i*ANGLE_W +: ANGLE_W]),
            .moving   (moving[i])
        );
    end

endmodule

// File: tb/tb_multi_spinner.sv
// Self-checking bench for multi_spinner: vector table plus hand-written
// sequences for held tick, coincident preset and asynchronous reset.
module tb_multi_spinner;

    localparam int NUM_CH  = 4;
    localparam int ANGLE_W = 6;
    localparam int AW      = NUM_CH * ANGLE_W;

    typedef struct {
        logic [3:0]    l;
        logic [3:0]    r;
        logic [3:0]    f;
        logic [3:0]    inv;
        logic          pre;
        logic [AW-1:0] ang;
        logic [3:0]    mov;
    } vec_t;

    typedef struct {
        logic [AW-1:0] ang;
        logic [3:0]    mov;
        logic [3:0]    mask;
        string         name;
    } exp_t;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          tick = 1'b0;
    logic          preset = 1'b0;
    logic [3:0]    btn_left = '0;
    logic [3:0]    btn_right = '0;
    logic [3:0]    btn_fast = '0;
    logic [3:0]    invert = '0;
    logic [AW-1:0] angle;
    logic [3:0]    moving;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vt[$];

    multi_spinner #(
        .NUM_CH     (NUM_CH),
        .ANGLE_W    (ANGLE_W),
        .MAX_STEP   (3),
        .ACC_HOLD   (4),
        .RESET_ANGLE(0)
    ) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .tick     (tick),
        .preset   (preset),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .btn_fast (btn_fast),
        .invert   (invert),
        .angle    (angle),
        .moving   (moving)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [AW-1:0] pk(input int a3, input int a2,
                                         input int a1, input int a0);
        return {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
    endfunction

    function automatic exp_t mk(input logic [AW-1:0] a, input logic [3:0] m,
                                input logic [3:0] k, input string n);
        exp_t e;
        e.ang  = a;
        e.mov  = m;
        e.mask = k;
        e.name = n;
        return e;
    endfunction

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: no expected entry queued");
            return;
        end
        e = sb.pop_front();
        for (int c = 0; c < NUM_CH; c++) begin
            if (e.mask[c]) begin
                checks++;
                if (angle[c*ANGLE_W +: ANGLE_W] !== e.ang[c*ANGLE_W +: ANGLE_W] ||
                    moving[c] !== e.mov[c]) begin
                    errors++;
                    $display("FAIL %s ch%0d: angle=%0d moving=%b, want angle=%0d moving=%b",
                             e.name, c, angle[c*ANGLE_W +: ANGLE_W], moving[c],
                             e.ang[c*ANGLE_W +: ANGLE_W], e.mov[c]);
                end
            end
        end
    endtask

    task automatic do_tick(input logic [3:0] l, input logic [3:0] r,
                           input logic [3:0] f, input logic [3:0] inv,
                           input logic pre, input exp_t e);
        @(negedge clk_sys);
        btn_left  = l;
        btn_right = r;
        btn_fast  = f;
        invert    = inv;
        preset    = pre;
        tick      = 1'b1;
        sb.push_back(e);
        @(posedge clk_sys);
        #1;
        preset = 1'b0;
        check_out();
        @(negedge clk_sys);
        tick = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic add(input logic [3:0] l, input logic [3:0] r,
                       input logic [3:0] f, input logic [3:0] inv,
                       input logic pre, input logic [AW-1:0] a,
                       input logic [3:0] m);
        vec_t v;
        v.l = l; v.r = r; v.f = f; v.inv = inv;
        v.pre = pre; v.ang = a; v.mov = m;
        vt.push_back(v);
    endtask

    initial begin
        int ramp[10];
        ramp = '{1, 2, 3, 4, 6, 8, 10, 12, 15, 18};

        #22;
        sb.push_back(mk('0, '0, 4'hF, "reset_state"));
        check_out();
        @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);

`ifdef MULTI_SPINNER_RECENTER_EN
        // Reach 35 on ch0: fast on the two step-1 ticks, then plain ramp.
        for (int t = 0; t < 15; t++)
            do_tick(4'h0, 4'h1, (t < 2) ? 4'h1 : 4'h0, 4'h0, 1'b0,
                    mk(pk(0, 0, 0, 35), 4'h1, (t == 14) ? 4'h1 : 4'h0, "rc_ramp"));
        do_tick('0, '0, '0, '0, 1'b0, mk(pk(0, 0, 0, 34), 4'h1, 4'h1, "rc_idle1"));
        do_tick('0, '0, '0, '0, 1'b0, mk(pk(0, 0, 0, 33), 4'h1, 4'h1, "rc_idle2"));
        do_tick('0, '0, '0, '0, 1'b0, mk(pk(0, 0, 0, 32), 4'h1, 4'h1, "rc_idle3"));
        do_tick('0, '0, '0, '0, 1'b0, mk(pk(0, 0, 0, 32), 4'h0, 4'h1, "rc_idle4"));
`else
        for (int k = 0; k < 10; k++)
            add(4'h0, 4'h1, 4'h0, 4'h0, 1'b0, pk(0, 0, 0, ramp[k]), 4'h1);
        add(4'h0, 4'h1, 4'h0, 4'h0, 1'b1, pk(0, 0, 0, 0), 4'h0);
        add(4'h2, 4'h0, 4'h0, 4'h0, 1'b0, pk(0, 0, 63, 0), 4'h2);
        add(4'h0, 4'h0, 4'h0, 4'h0, 1'b1, pk(0, 0, 0, 0), 4'h0);
        add(4'h0, 4'h2, 4'h2, 4'h0, 1'b0, pk(0, 0, 2, 0), 4'h2);
        add(4'h0, 4'h0, 4'h0, 4'h0, 1'b1, pk(0, 0, 0, 0), 4'h0);
        add(4'h2, 4'h0, 4'h2, 4'h0, 1'b0, pk(0, 0, 62, 0), 4'h2);
        add(4'h0, 4'h2, 4'h2, 4'h0, 1'b0, pk(0, 0, 0, 0), 4'h2);
        for (int k = 1; k <= 4; k++)
            add(4'h0, 4'h4, 4'h0, 4'h0, 1'b0, pk(0, k, 0, 0), 4'h4);
        add(4'h4, 4'h4, 4'h0, 4'h0, 1'b0, pk(0, 4, 0, 0), 4'h0);
        add(4'h0, 4'h4, 4'h0, 4'h0, 1'b0, pk(0, 5, 0, 0), 4'h4);
        add(4'h0, 4'h4, 4'h0, 4'h0, 1'b0, pk(0, 6, 0, 0), 4'h4);
        add(4'h4, 4'h0, 4'h0, 4'h0, 1'b0, pk(0, 5, 0, 0), 4'h4);
        add(4'h0, 4'h8, 4'h0, 4'h8, 1'b0, pk(63, 5, 0, 0), 4'h8);

        for (int i = 0; i < vt.size(); i++)
            do_tick(vt[i].l, vt[i].r, vt[i].f, vt[i].inv, vt[i].pre,
                    mk(vt[i].ang, vt[i].mov, 4'hF, $sformatf("vec%0d", i)));

        // Tick held high for 50 cycles: exactly one update.
        @(negedge clk_sys);
        btn_left = '0; btn_right = 4'h8; btn_fast = '0; invert = 4'h8;
        tick = 1'b1;
        sb.push_back(mk(pk(62, 5, 0, 0), 4'h8, 4'hF, "held_tick"));
        repeat (50) @(posedge clk_sys);
        #1;
        check_out();
        @(negedge clk_sys);
        tick = 1'b0;
        @(negedge clk_sys);

        do_tick('0, '0, '0, '0, 1'b1, mk('0, '0, 4'hF, "preset_clear"));
        for (int k = 0; k < 5; k++)
            do_tick(4'h0, 4'h1, 4'h0, 4'h0, 1'b0,
                    mk(pk(0, 0, 0, ramp[k]), 4'h1, 4'hF, "pre_reset_ramp"));

        // Asynchronous reset between edges, then release with tick high.
        @(negedge clk_sys);
        #2;
        reset_n = 1'b0;
        #1;
        sb.push_back(mk('0, '0, 4'hF, "async_reset"));
        check_out();
        tick = 1'b1;
        @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        sb.push_back(mk('0, '0, 4'hF, "tick_high_release"));
        check_out();
        @(negedge clk_sys);
        tick = 1'b0;
        @(negedge clk_sys);
        do_tick(4'h0, 4'h1, 4'h0, 4'h0, 1'b0,
                mk(pk(0, 0, 0, 1), 4'h1, 4'hF, "post_reset_step1"));
`endif

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
